// File: rtl/huffman_pkg.sv
// Shared encodings for the Huffman block sequencer: symbol types,
// sequencer FSM states and the zero-run-length escape constant.
package huffman_pkg;

    localparam logic [1:0] SYM_DC  = 2'd0;
    localparam logic [1:0] SYM_AC  = 2'd1;
    localparam logic [1:0] SYM_ZRL = 2'd2;
    localparam logic [1:0] SYM_EOB = 2'd3;

    // A run of 16 zeros is escaped as ZRL carrying run 15
    localparam logic [3:0] ZRL_RUN = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DC   = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

endpackage

// File: rtl/huffman_magnitude.sv
// Combinational JPEG magnitude coder: bit-length category of |value| and
// the right-aligned amplitude bits (value, or value-1 masked to size bits
// when negative). Shared by the DC-difference and AC-coefficient paths.
module huffman_magnitude
    import huffman_pkg::*;
#(
    parameter int PIX_W  = 8,
    parameter int SIZE_W = 4
) (
    input  logic [PIX_W:0]    value,
    output logic [SIZE_W-1:0] size,
    output logic [PIX_W:0]    bits
);

    localparam logic [PIX_W:0] ONE = {{PIX_W{1'b0}}, 1'b1};

    logic [PIX_W:0]    abs_s;
    logic [PIX_W:0]    mask_s;
    logic [PIX_W:0]    minus_one_s;
    logic [PIX_W:0]    bits_s;
    logic [SIZE_W-1:0] size_s;

    // Category from the highest set bit of |value|, then amplitude masking
    always_comb begin
        abs_s  = value[PIX_W] ? (~value + ONE) : value;
        size_s = '0;
        for (int i = 0; i <= PIX_W; i++) begin
            size_s = abs_s[i] ? SIZE_W'(i + 1) : size_s;
        end
        for (int i = 0; i <= PIX_W; i++) begin
            mask_s[i] = (i < int'(size_s)) ? 1'b1 : 1'b0;
        end
        minus_one_s = value - ONE;
        bits_s      = value[PIX_W] ? (minus_one_s & mask_s) : value;
    end

    assign size = size_s;
    assign bits = bits_s;

endmodule

// File: rtl/huffman_block_sequencer.sv
// Walks one zigzag-ordered coefficient block per handshake and emits JPEG
// entropy symbols (DC diff, AC run/size, ZRL, EOB) through a registered,
// back-pressured symbol port. One DC predictor is kept per channel.
// Optional build macro HUFF_STATS_EN adds per-block symbol statistics.
module huffman_block_sequencer
    import huffman_pkg::*;
#(
    parameter int PIX_W  = 8,
    parameter int N_COEF = 64,
    parameter int NUM_CH = 3,
    parameter int CH_W   = 2,
    parameter int SIZE_W = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      blk_valid,
    output logic                      blk_ready,
    input  logic [N_COEF*PIX_W-1:0]   blk_data,
    input  logic [CH_W-1:0]           blk_ch,
    input  logic                      blk_restart,
    output logic                      sym_valid,
    input  logic                      sym_ready,
    output logic [1:0]                sym_type,
    output logic [3:0]                sym_run,
    output logic [SIZE_W-1:0]         sym_size,
    output logic [PIX_W:0]            sym_bits,
    output logic                      sym_last,
`ifdef HUFF_STATS_EN
    output logic [7:0]                blk_sym_count,
    output logic                      blk_stats_valid,
`endif
    output logic                      busy
);

    localparam int IDX_W = (N_COEF > 1) ? $clog2(N_COEF) : 1;

    state_t                    state_r;
    logic [N_COEF*PIX_W-1:0]   coef_r;
    logic [CH_W-1:0]           ch_r;
    logic                      restart_r;
    logic [IDX_W-1:0]          last_nz_r;
    logic [IDX_W-1:0]          idx_r;
    logic [3:0]                run_r;
    logic [PIX_W-1:0]          pred_r [NUM_CH];

    logic                      blk_ready_r;
    logic                      sym_valid_r;
    logic [1:0]                sym_type_r;
    logic [3:0]                sym_run_r;
    logic [SIZE_W-1:0]         sym_size_r;
    logic [PIX_W:0]            sym_bits_r;
    logic                      sym_last_r;

    logic [CH_W-1:0]           ch_in_s;
    logic [IDX_W-1:0]          last_nz_in_s;
    logic [PIX_W-1:0]          cur_coef_s;
    logic [PIX_W-1:0]          coef0_s;
    logic [PIX_W-1:0]          pred_s;
    logic [PIX_W:0]            dc_diff_s;
    logic [PIX_W:0]            mag_in_s;
    logic [SIZE_W-1:0]         mag_size_s;
    logic [PIX_W:0]            mag_bits_s;
    logic                      can_load_s;

    // Channel folding and highest-nonzero-AC search on the incoming block
    always_comb begin
        ch_in_s      = (32'(blk_ch) < NUM_CH) ? blk_ch : '0;
        last_nz_in_s = '0;
        for (int i = 1; i < N_COEF; i++) begin
            last_nz_in_s = (blk_data[(N_COEF-1-i)*PIX_W +: PIX_W] != '0) ?
                           IDX_W'(i) : last_nz_in_s;
        end
    end

    // Current coefficient, DC difference at PIX_W+1 bits and magnitude input select
    always_comb begin
        cur_coef_s = coef_r[(N_COEF-1-int'(idx_r))*PIX_W +: PIX_W];
        coef0_s    = coef_r[N_COEF*PIX_W-1 -: PIX_W];
        pred_s     = restart_r ? '0 : pred_r[ch_r];
        dc_diff_s  = {coef0_s[PIX_W-1], coef0_s} - {pred_s[PIX_W-1], pred_s};
        mag_in_s   = (state_r == ST_DC) ? dc_diff_s : {cur_coef_s[PIX_W-1], cur_coef_s};
        can_load_s = !sym_valid_r || sym_ready;
    end

    huffman_magnitude #(
        .PIX_W  (PIX_W),
        .SIZE_W (SIZE_W)
    ) u_magnitude (
        .value (mag_in_s),
        .size  (mag_size_s),
        .bits  (mag_bits_s)
    );

    // Sequencer FSM with the registered symbol output stage
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            coef_r      <= '0;
            ch_r        <= '0;
            restart_r   <= 1'b0;
            last_nz_r   <= '0;
            idx_r       <= '0;
            run_r       <= 4'd0;
            for (int c = 0; c < NUM_CH; c++) begin
                pred_r[c] <= '0;
            end
            blk_ready_r <= 1'b0;
            sym_valid_r <= 1'b0;
            sym_type_r  <= 2'd0;
            sym_run_r   <= 4'd0;
            sym_size_r  <= '0;
            sym_bits_r  <= '0;
            sym_last_r  <= 1'b0;
        end else begin
            if (sym_valid_r && sym_ready) begin
                sym_valid_r <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (blk_valid && blk_ready_r) begin
                        coef_r      <= blk_data;
                        ch_r        <= ch_in_s;
                        restart_r   <= blk_restart;
                        last_nz_r   <= last_nz_in_s;
                        blk_ready_r <= 1'b0;
                        state_r     <= ST_DC;
                    end else begin
                        blk_ready_r <= 1'b1;
                    end
                end
                ST_DC: begin
                    if (can_load_s) begin
                        sym_valid_r  <= 1'b1;
                        sym_type_r   <= SYM_DC;
                        sym_run_r    <= 4'd0;
                        sym_size_r   <= mag_size_s;
                        sym_bits_r   <= mag_bits_s;
                        sym_last_r   <= 1'b0;
                        pred_r[ch_r] <= coef0_s;
                        idx_r        <= IDX_W'(1);
                        run_r        <= 4'd0;
                        state_r      <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (can_load_s) begin
                        if (idx_r > last_nz_r) begin
                            sym_valid_r <= 1'b1;
                            sym_type_r  <= SYM_EOB;
                            sym_run_r   <= 4'd0;
                            sym_size_r  <= '0;
                            sym_bits_r  <= '0;
                            sym_last_r  <= 1'b1;
                            idx_r       <= '0;
                            run_r       <= 4'd0;
                            blk_ready_r <= 1'b1;
                            state_r     <= ST_IDLE;
                        end else if (cur_coef_s == '0) begin
                            if (run_r == ZRL_RUN) begin
                                sym_valid_r <= 1'b1;
                                sym_type_r  <= SYM_ZRL;
                                sym_run_r   <= ZRL_RUN;
                                sym_size_r  <= '0;
                                sym_bits_r  <= '0;
                                sym_last_r  <= 1'b0;
                                run_r       <= 4'd0;
                            end else begin
                                run_r <= run_r + 4'd1;
                            end
                            idx_r <= idx_r + IDX_W'(1);
                        end else begin
                            sym_valid_r <= 1'b1;
                            sym_type_r  <= SYM_AC;
                            sym_run_r   <= run_r;
                            sym_size_r  <= mag_size_s;
                            sym_bits_r  <= mag_bits_s;
                            run_r       <= 4'd0;
                            if (idx_r == IDX_W'(N_COEF-1)) begin
                                sym_last_r  <= 1'b1;
                                idx_r       <= '0;
                                blk_ready_r <= 1'b1;
                                state_r     <= ST_IDLE;
                            end else begin
                                sym_last_r  <= 1'b0;
                                idx_r       <= idx_r + IDX_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    blk_ready_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef HUFF_STATS_EN
    logic [7:0] sym_count_r;
    logic       stats_valid_r;

    // Per-block accepted-symbol counter and completion pulse on the last symbol
    always_ff @(posedge clock) begin
        if (reset) begin
            sym_count_r   <= 8'd0;
            stats_valid_r <= 1'b0;
        end else begin
            stats_valid_r <= sym_valid_r && sym_ready && sym_last_r;
            if (sym_valid_r && sym_ready) begin
                sym_count_r <= (sym_type_r == SYM_DC) ? 8'd1 : (sym_count_r + 8'd1);
            end
        end
    end

    assign blk_sym_count   = sym_count_r;
    assign blk_stats_valid = stats_valid_r;
`endif

    assign blk_ready = blk_ready_r;
    assign sym_valid = sym_valid_r;
    assign sym_type  = sym_type_r;
    assign sym_run   = sym_run_r;
    assign sym_size  = sym_size_r;
    assign sym_bits  = sym_bits_r;
    assign sym_last  = sym_last_r;
    assign busy      = (state_r != ST_IDLE) || sym_valid_r;

endmodule

// File: tb/tb_huffman_block_sequencer.sv
// Directed, table-driven bench for huffman_block_sequencer: a vector table of
// blocks with hand-computed symbol sequences, plus hand-written sequences for
// back-pressure, predictor restart and mid-block reset.
`timescale 1ns/1ps
module tb_huffman_block_sequencer;

    localparam int PIX_W  = 8;
    localparam int N_COEF = 64;
    localparam int NUM_CH = 3;
    localparam int CH_W   = 2;
    localparam int SIZE_W = 4;
    localparam int NV     = 8;

    typedef struct packed {
        logic [1:0] t;
        logic [3:0] run;
        logic [3:0] size;
        logic [8:0] bits;
        logic       last;
    } sym_t;

    typedef struct packed {
        logic [7:0]     c0;
        logic [1:0]     ch;
        logic           rst;
        logic [5:0]     ac_idx;
        logic [7:0]     ac_val;
        logic [2:0]     nsym;
        sym_t [4:0]     syms;
    } vec_t;

    logic                    clock = 1'b0;
    logic                    reset = 1'b1;
    logic                    blk_valid = 1'b0;
    logic                    blk_ready;
    logic [N_COEF*PIX_W-1:0] blk_data = '0;
    logic [CH_W-1:0]         blk_ch = '0;
    logic                    blk_restart = 1'b0;
    logic                    sym_valid;
    logic                    sym_ready = 1'b1;
    logic [1:0]              sym_type;
    logic [3:0]              sym_run;
    logic [SIZE_W-1:0]       sym_size;
    logic [PIX_W:0]          sym_bits;
    logic                    sym_last;
    logic                    busy;
`ifdef HUFF_STATS_EN
    logic [7:0]              blk_sym_count;
    logic                    blk_stats_valid;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    vec_t vecs [NV];

    always #5 clock = ~clock;

    huffman_block_sequencer #(
        .PIX_W  (PIX_W),
        .N_COEF (N_COEF),
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W),
        .SIZE_W (SIZE_W)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .blk_valid       (blk_valid),
        .blk_ready       (blk_ready),
        .blk_data        (blk_data),
        .blk_ch          (blk_ch),
        .blk_restart     (blk_restart),
        .sym_valid       (sym_valid),
        .sym_ready       (sym_ready),
        .sym_type        (sym_type),
        .sym_run         (sym_run),
        .sym_size        (sym_size),
        .sym_bits        (sym_bits),
        .sym_last        (sym_last),
`ifdef HUFF_STATS_EN
        .blk_sym_count   (blk_sym_count),
        .blk_stats_valid (blk_stats_valid),
`endif
        .busy            (busy)
    );

    function automatic sym_t mk(input logic [1:0] t, input logic [3:0] r,
                                input logic [3:0] s, input logic [8:0] b, input logic l);
        sym_t x;
        x = {t, r, s, b, l};
        return x;
    endfunction

    function automatic vec_t mkv(input logic [7:0] c0, input logic [1:0] ch, input logic rst,
                                 input logic [5:0] ai, input logic [7:0] av, input logic [2:0] n,
                                 input sym_t s0, input sym_t s1, input sym_t s2,
                                 input sym_t s3, input sym_t s4);
        vec_t v;
        v.c0 = c0; v.ch = ch; v.rst = rst; v.ac_idx = ai; v.ac_val = av; v.nsym = n;
        v.syms[0] = s0; v.syms[1] = s1; v.syms[2] = s2; v.syms[3] = s3; v.syms[4] = s4;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic chk_sym(input string name, input sym_t exp);
        sym_t act;
        act = {sym_type, sym_run, sym_size, sym_bits, sym_last};
        n_checks++;
        if (sym_valid === 1'b1 && act === exp) n_pass++;
        else $display("FAIL %s: got valid=%0b type=%0d run=%0d size=%0d bits=0x%0h last=%0b expected type=%0d run=%0d size=%0d bits=0x%0h last=%0b",
                      name, sym_valid, act.t, act.run, act.size, act.bits, act.last,
                      exp.t, exp.run, exp.size, exp.bits, exp.last);
    endtask

    // Advance (bounded) until a symbol is presented; a timeout shows up in chk_sym
    task automatic wait_sym();
        int w = 0;
        while (sym_valid !== 1'b1 && w < 200) begin
            @(negedge clock);
            w++;
        end
    endtask

    // Called at a negedge; returns at the negedge after the block is accepted
    task automatic send_block(input logic [7:0] c0, input logic [1:0] ch, input logic rst,
                              input int ai, input logic [7:0] av);
        logic [N_COEF*PIX_W-1:0] d;
        int w = 0;
        d = '0;
        d[N_COEF*PIX_W-1 -: PIX_W] = c0;
        if (ai != 0) d[(N_COEF-1-ai)*PIX_W +: PIX_W] = av;
        blk_data = d; blk_ch = ch; blk_restart = rst; blk_valid = 1'b1;
        while (blk_ready !== 1'b1 && w < 200) begin
            @(negedge clock);
            w++;
        end
        chk("blk_accept", 32'(blk_ready), 32'd1);
        @(negedge clock);
        blk_valid = 1'b0;
        blk_restart = 1'b0;
    endtask

    initial begin
        sym_t none, eob;
        none = '0;
        eob  = mk(2'd3, 4'd0, 4'd0, 9'h000, 1'b1);

        vecs[0] = mkv(8'd10, 2'd0, 1'b0, 6'd0,  8'h00, 3'd2, mk(2'd0, 4'd0, 4'd4, 9'h00A, 1'b0), eob, none, none, none);
        vecs[1] = mkv(8'd7,  2'd0, 1'b0, 6'd0,  8'h00, 3'd2, mk(2'd0, 4'd0, 4'd2, 9'h000, 1'b0), eob, none, none, none);
        vecs[2] = mkv(8'd7,  2'd1, 1'b0, 6'd0,  8'h00, 3'd2, mk(2'd0, 4'd0, 4'd3, 9'h007, 1'b0), eob, none, none, none);
        vecs[3] = mkv(8'd0,  2'd2, 1'b0, 6'd20, 8'hFF, 3'd4, mk(2'd0, 4'd0, 4'd0, 9'h000, 1'b0),
                      mk(2'd2, 4'd15, 4'd0, 9'h000, 1'b0), mk(2'd1, 4'd3, 4'd1, 9'h000, 1'b0), eob, none);
        vecs[4] = mkv(8'd0,  2'd2, 1'b0, 6'd63, 8'h01, 3'd5, mk(2'd0, 4'd0, 4'd0, 9'h000, 1'b0),
                      mk(2'd2, 4'd15, 4'd0, 9'h000, 1'b0), mk(2'd2, 4'd15, 4'd0, 9'h000, 1'b0),
                      mk(2'd2, 4'd15, 4'd0, 9'h000, 1'b0), mk(2'd1, 4'd14, 4'd1, 9'h001, 1'b1));
        vecs[5] = mkv(8'h80, 2'd0, 1'b0, 6'd0,  8'h00, 3'd2, mk(2'd0, 4'd0, 4'd8, 9'h078, 1'b0), eob, none, none, none);
        vecs[6] = mkv(8'h7F, 2'd0, 1'b0, 6'd0,  8'h00, 3'd2, mk(2'd0, 4'd0, 4'd8, 9'h0FF, 1'b0), eob, none, none, none);
        vecs[7] = mkv(8'h80, 2'd3, 1'b0, 6'd1,  8'h80, 3'd3, mk(2'd0, 4'd0, 4'd8, 9'h000, 1'b0),
                      mk(2'd1, 4'd0, 4'd8, 9'h07F, 1'b0), eob, none, none);

        // Reset state
        repeat (3) @(negedge clock);
        chk("reset_outputs", 32'({sym_valid, blk_ready, busy, sym_type, sym_run, sym_size, sym_bits, sym_last}), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("ready_after_reset", 32'(blk_ready), 32'd1);

        // Table-driven blocks with free-flowing output
        for (int v = 0; v < NV; v++) begin
            send_block(vecs[v].c0, vecs[v].ch, vecs[v].rst, int'(vecs[v].ac_idx), vecs[v].ac_val);
            for (int k = 0; k < int'(vecs[v].nsym); k++) begin
                wait_sym();
                chk_sym($sformatf("vec%0d_sym%0d", v, k), vecs[v].syms[k]);
                @(negedge clock);
            end
            chk($sformatf("vec%0d_no_extra", v), 32'(sym_valid), 32'd0);
            chk($sformatf("vec%0d_ready_back", v), 32'(blk_ready), 32'd1);
        end

        // Back-pressure: AC symbol held for several cycles; restart clears ch1 predictor (7)
        sym_ready = 1'b0;
        send_block(8'd5, 2'd1, 1'b1, 2, 8'd3);
        wait_sym();
        chk_sym("stall_dc_restart", mk(2'd0, 4'd0, 4'd3, 9'h005, 1'b0));
        sym_ready = 1'b1;
        @(negedge clock);
        sym_ready = 1'b0;
        wait_sym();
        for (int i = 0; i < 5; i++) begin
            chk_sym($sformatf("stall_hold%0d", i), mk(2'd1, 4'd1, 4'd2, 9'h003, 1'b0));
            @(negedge clock);
        end
        chk_sym("stall_hold_end", mk(2'd1, 4'd1, 4'd2, 9'h003, 1'b0));
        sym_ready = 1'b1;
        @(negedge clock);
        chk_sym("stall_eob", eob);
        @(negedge clock);
        chk("stall_no_extra", 32'(sym_valid), 32'd0);

        // Reset during SCAN; ch0 predictor is -128 here, so DC diff 148
        send_block(8'd20, 2'd0, 1'b0, 63, 8'd1);
        wait_sym();
        chk_sym("rst_blk_dc", mk(2'd0, 4'd0, 4'd8, 9'h094, 1'b0));
        repeat (4) @(negedge clock);
        chk("busy_in_scan", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        chk("midblock_reset_outputs", 32'({sym_valid, blk_ready, busy, sym_type, sym_run, sym_size, sym_bits, sym_last}), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        send_block(8'd20, 2'd0, 1'b0, 0, 8'd0);
        wait_sym();
        chk_sym("post_reset_dc", mk(2'd0, 4'd0, 4'd5, 9'h014, 1'b0));
        @(negedge clock);
        wait_sym();
        chk_sym("post_reset_eob", eob);
        @(negedge clock);
        chk("post_reset_idle", 32'({busy, blk_ready}), 32'b01);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
